// File: rtl/read_fifo16.sv
// 16-bit FIFO filled from the Clk domain and drained by an asynchronous CPU
// read strobe; Rd/En/Addr are synchronized and a pop fires on the strobe's trailing edge.
module read_fifo16 #(
  parameter int DEPTH = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Push,
  input  logic [15:0] PushData,
  output logic        Full,
  output logic        Empty,
  input  logic        En,
  input  logic        Rd,
  input  logic        Addr,
  output logic [15:0] DataRd
);
  localparam int PW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [4:0]    count;
  logic          overflow, underflow;
  logic          rdS1, rdS2, rdS3, enS1, enS2, addrS1, addrS2;
  logic          access, popReq, clrReq, popOk, pushOk;
  logic [15:0]   status;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {rdS1, rdS2, rdS3}   <= '0;
      {enS1, enS2}         <= '0;
      {addrS1, addrS2}     <= '0;
    end else begin
      rdS1   <= Rd;
      rdS2   <= rdS1;
      rdS3   <= rdS2;
      enS1   <= En;
      enS2   <= enS1;
      addrS1 <= Addr;
      addrS2 <= addrS1;
    end
  end

  // Trailing edge of the strobe: a Rd fall before edge k is acted on at edge k+2.
  assign access = rdS3 & ~rdS2 & enS2;
  assign popReq = access & ~addrS2;
  assign clrReq = access & addrS2;

  assign Empty  = (count == 5'd0);
  assign Full   = (count == 5'(DEPTH));
  assign popOk  = popReq & ~Empty;
  // When full, a concurrent pop frees the slot the push is about to reuse.
  assign pushOk = Push & (~Full | popOk);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (popOk)  rdPtr <= rdPtr + PW'(1);
      count     <= count + 5'(pushOk) - 5'(popOk);
      // Sticky flags: a status read clears them, but a fresh event that cycle wins.
      overflow  <= (Push & ~pushOk) | (overflow & ~clrReq);
      underflow <= (popReq & Empty) | (underflow & ~clrReq);
    end
  end

  always_ff @(posedge Clk) begin
    if (pushOk) mem[wrPtr] <= PushData;
  end

  always_comb begin
    status = {7'b0, underflow, overflow, Full, Empty, count};
    DataRd = 16'h0000;
    if (Addr)        DataRd = status;
    else if (!Empty) DataRd = mem[rdPtr];
  end
endmodule

// File: tb/tb_read_fifo16.sv
// Directed bench for read_fifo16: stimulus queues expectations, a negedge monitor checks them.
module tb_read_fifo16;
  logic        Clk = 1'b0, Reset = 1'b1, Push = 1'b0, En = 1'b0, Rd = 1'b0, Addr = 1'b0;
  logic [15:0] PushData = '0;
  logic        Full, Empty;
  logic [15:0] DataRd;

  read_fifo16 #(.DEPTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Push(Push), .PushData(PushData),
    .Full(Full), .Empty(Empty), .En(En), .Rd(Rd), .Addr(Addr), .DataRd(DataRd)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        full;
    logic        empty;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({Full, Empty, DataRd} !== {e.full, e.empty, e.data}) begin
        failures++;
        $display("FAIL %s: got data=%h full=%b empty=%b, expected data=%h full=%b empty=%b",
                 e.name, DataRd, Full, Empty, e.data, e.full, e.empty);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] d, input logic f, input logic e);
    exp_t x;
    x.name = nm; x.data = d; x.full = f; x.empty = e;
    q.push_back(x);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); #1;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s: monitor timeout, pending=%0d required=0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic pushW(input logic [15:0] d);
    Push = 1'b1; PushData = d;
    @(posedge Clk); #1;
    Push = 1'b0;
  endtask

  // Strobe Rd for 3 periods; optional Push lands on the same edge as the pop (k+2).
  task automatic cpuRead(input logic a, input logic en, input logic doPush, input logic [15:0] pd);
    Addr = a; En = en; Rd = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rd = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    if (doPush) begin Push = 1'b1; PushData = pd; end
    @(posedge Clk); #1;
    Push = 1'b0; En = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;

    // Reset state
    Addr = 1'b1; chk("rst_status", 16'h0020, 1'b0, 1'b1);
    Addr = 1'b0; chk("rst_data",   16'h0000, 1'b0, 1'b1);

    // Two pushes, two data reads
    pushW(16'h1234); pushW(16'hBEEF);
    Addr = 1'b1; chk("two_status", 16'h0002, 1'b0, 1'b0);
    Addr = 1'b0; chk("head_1234",  16'h1234, 1'b0, 1'b0);
    cpuRead(1'b0, 1'b1, 1'b0, 16'h0);
    chk("head_beef", 16'hBEEF, 1'b0, 1'b0);
    Addr = 1'b1; chk("one_status", 16'h0001, 1'b0, 1'b0);
    cpuRead(1'b0, 1'b1, 1'b0, 16'h0);
    chk("drained_data", 16'h0000, 1'b0, 1'b1);
    Addr = 1'b1; chk("drained_status", 16'h0020, 1'b0, 1'b1);

    // Read while empty -> underflow, pointers untouched
    cpuRead(1'b0, 1'b1, 1'b0, 16'h0);
    chk("empty_read_data", 16'h0000, 1'b0, 1'b1);
    Addr = 1'b1; chk("underflow_status", 16'h0120, 1'b0, 1'b1);
    pushW(16'h5555);
    chk("underflow_sticky", 16'h0101, 1'b0, 1'b0);
    Addr = 1'b0; chk("ptr_unchanged", 16'h5555, 1'b0, 1'b0);
    cpuRead(1'b1, 1'b1, 1'b0, 16'h0);
    chk("uflow_cleared", 16'h0001, 1'b0, 1'b0);
    cpuRead(1'b0, 1'b1, 1'b0, 16'h0);
    Addr = 1'b1; chk("empty_again", 16'h0020, 1'b0, 1'b1);

    // Overfill: ninth push dropped
    for (int i = 0; i < 9; i++) pushW(16'h1000 + 16'(i));
    chk("full_status", 16'h00C8, 1'b1, 1'b0);
    cpuRead(1'b1, 1'b1, 1'b0, 16'h0);
    chk("oflow_cleared", 16'h0048, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      Addr = 1'b0; chk("drain_head", 16'h1000 + 16'(i), (i == 0), 1'b0);
      cpuRead(1'b0, 1'b1, 1'b0, 16'h0);
    end
    Addr = 1'b1; chk("count3_status", 16'h0003, 1'b0, 1'b0);

    // Simultaneous push/pop at count 3 across pointer wrap
    for (int i = 0; i < 20; i++) begin
      Addr = 1'b0;
      chk("wrap_head", (i < 3) ? 16'h1005 + 16'(i) : 16'h2000 + 16'(i - 3), 1'b0, 1'b0);
      cpuRead(1'b0, 1'b1, 1'b1, 16'h2000 + 16'(i));
      Addr = 1'b1; chk("wrap_count", 16'h0003, 1'b0, 1'b0);
    end

    // Pop latency: Rd falls before edge k, head changes after edge k+2
    Addr = 1'b0; En = 1'b1; Rd = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rd = 1'b0;
    @(posedge Clk); chk("lat_k",   16'h2011, 1'b0, 1'b0);
    @(posedge Clk); chk("lat_k+1", 16'h2011, 1'b0, 1'b0);
    @(posedge Clk); chk("lat_k+2", 16'h2012, 1'b0, 1'b0);
    En = 1'b0;
    @(posedge Clk); #1;
    cpuRead(1'b0, 1'b0, 1'b0, 16'h0);
    chk("en0_no_pop", 16'h2012, 1'b0, 1'b0);
    Addr = 1'b1; chk("en0_status", 16'h0002, 1'b0, 1'b0);

    // Reset mid-strobe with count 4
    pushW(16'h3000); pushW(16'h3001);
    chk("count4_status", 16'h0004, 1'b0, 1'b0);
    Addr = 1'b0; En = 1'b1; Rd = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    chk("rst_mid_data", 16'h0000, 1'b0, 1'b1);
    Addr = 1'b1; chk("rst_mid_status", 16'h0020, 1'b0, 1'b1);
    Addr = 1'b0; Rd = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1 En = 1'b0; Addr = 1'b1;
    chk("post_rst_status", 16'h0020, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule
